// File: rtl/bcd_score_tracker.sv
// rtl/bcd_score_tracker.sv - parametrised BCD score accumulator with saturation, high score and milestones
module bcd_score_tracker #(
   parameter int DIGITS   = 6,
   parameter int MS_DIGIT = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  clear,
   input  logic                  inc_en,
   input  logic [3:0]            inc_amt,
   input  logic                  commit,
   output logic [4*DIGITS-1:0]   score,
   output logic [4*DIGITS-1:0]   hiscore,
   output logic                  new_hi,
   output logic                  milestone,
   output logic                  saturated
);

   localparam int             W         = 4 * DIGITS;
   localparam logic [W-1:0]   ALL_NINES = {DIGITS{4'h9}};

   logic [3:0]        amt;
   logic [4:0]        ones_sum;
   logic              gen0;
   logic [DIGITS:1]   carry;
   logic [W-1:0]      sum_score;
   logic              inc_go;
   logic              overflow;
   logic              ms_change;
   logic              hi_win;

   // Clamp the step to a legal BCD digit and add it into the ones digit.
   always_comb begin
      amt      = (inc_amt > 4'd9) ? 4'd9 : inc_amt;
      ones_sum = {1'b0, score[3:0]} + {1'b0, amt};
      gen0     = (ones_sum >= 5'd10);
   end

   // Carry into digit k exists only if the ones digit generated one and every
   // digit between them is a 9; the 9-detects are parallel so the chain is a
   // plain AND ladder rather than a chain of adders.
   always_comb begin
      carry    = '0;
      carry[1] = gen0;
      for (int k = 1; k < DIGITS; k++) begin
         carry[k+1] = carry[k] & (score[4*k +: 4] == 4'd9);
      end
   end

   // Form the candidate sum: ones digit wraps by adding 6 mod 16 (same as -10),
   // upper digits either increment or wrap 9 -> 0 when a carry reaches them.
   always_comb begin
      sum_score      = score;
      sum_score[3:0] = gen0 ? (ones_sum[3:0] + 4'd6) : ones_sum[3:0];
      for (int k = 1; k < DIGITS; k++) begin
         if (carry[k]) begin
            sum_score[4*k +: 4] = (score[4*k +: 4] == 4'd9) ? 4'd0
                                                             : (score[4*k +: 4] + 4'd1);
         end
      end
   end

   // Acceptance, overflow, milestone and high-score decisions for this edge.
   always_comb begin
      inc_go    = inc_en && !clear && !saturated && (amt != 4'd0);
      overflow  = carry[DIGITS];
      ms_change = (sum_score[4*MS_DIGIT +: 4] != score[4*MS_DIGIT +: 4]);
      hi_win    = commit && (score > hiscore);
   end

   // State update: commit sees the old score, clear beats increment, pulses last one cycle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         score     <= '0;
         hiscore   <= '0;
         new_hi    <= 1'b0;
         milestone <= 1'b0;
         saturated <= 1'b0;
      end else begin
         new_hi    <= 1'b0;
         milestone <= 1'b0;
         if (hi_win) begin
            hiscore <= score;
            new_hi  <= 1'b1;
         end
         if (clear) begin
            score     <= '0;
            saturated <= 1'b0;
         end else if (inc_go) begin
            if (overflow) begin
               score     <= ALL_NINES;
               saturated <= 1'b1;
            end else begin
               score     <= sum_score;
               milestone <= ms_change;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_score_tracker.sv
// tb/tb_bcd_score_tracker.sv - self-checking bench for bcd_score_tracker
module tb_bcd_score_tracker;

   typedef struct packed {
      int unsigned sc;
      int unsigned hi;
      bit          nh;
      bit          ms;
      bit          sat;
   } mstate_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        clear = 1'b0;
   logic        inc_en = 1'b0;
   logic [3:0]  inc_amt = 4'd0;
   logic        commit = 1'b0;

   logic [23:0] score, hiscore;
   logic        new_hi, milestone, saturated;
   logic [11:0] score_s, hiscore_s;
   logic        new_hi_s, milestone_s, saturated_s;

   int          errors = 0;
   int          checks = 0;
   bit          chk_en = 1'b0;
   int          ms_cnt = 0;
   int          ms_cnt_s = 0;
   int          base;
   mstate_t     m  = '0;
   mstate_t     ms = '0;

   bcd_score_tracker u_dut (
      .clk(clk), .resetn(resetn), .clear(clear), .inc_en(inc_en),
      .inc_amt(inc_amt), .commit(commit), .score(score), .hiscore(hiscore),
      .new_hi(new_hi), .milestone(milestone), .saturated(saturated)
   );

   bcd_score_tracker #(.DIGITS(3), .MS_DIGIT(1)) u_small (
      .clk(clk), .resetn(resetn), .clear(clear), .inc_en(inc_en),
      .inc_amt(inc_amt), .commit(commit), .score(score_s), .hiscore(hiscore_s),
      .new_hi(new_hi_s), .milestone(milestone_s), .saturated(saturated_s)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] to_bcd(int unsigned v);
      logic [31:0] r;
      int unsigned x;
      r = '0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Decimal-arithmetic model of one clock edge.
   function automatic mstate_t model_next(mstate_t c, int unsigned maxv, int unsigned msw,
                                          bit rn, bit cl, bit ie, logic [3:0] amt, bit cm);
      mstate_t     n;
      int unsigned a, s;
      n    = c;
      n.nh = 1'b0;
      n.ms = 1'b0;
      if (!rn) begin
         n = '0;
      end else begin
         if (cm && c.sc > c.hi) begin
            n.hi = c.sc;
            n.nh = 1'b1;
         end
         if (cl) begin
            n.sc  = 0;
            n.sat = 1'b0;
         end else if (ie && !c.sat) begin
            a = (amt > 9) ? 9 : int'(amt);
            if (a != 0) begin
               s = c.sc + a;
               if (s > maxv) begin
                  n.sc  = maxv;
                  n.sat = 1'b1;
               end else begin
                  n.ms = ((c.sc / msw) % 10) != ((s / msw) % 10);
                  n.sc = s;
               end
            end
         end
      end
      return n;
   endfunction

   always @(posedge clk) begin
      m  <= model_next(m,  999999, 100, resetn, clear, inc_en, inc_amt, commit);
      ms <= model_next(ms, 999,    10,  resetn, clear, inc_en, inc_amt, commit);
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare both instances against the model every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         check("score",       32'(score),       to_bcd(m.sc));
         check("hiscore",     32'(hiscore),     to_bcd(m.hi));
         check("new_hi",      32'(new_hi),      32'(m.nh));
         check("milestone",   32'(milestone),   32'(m.ms));
         check("saturated",   32'(saturated),   32'(m.sat));
         check("s_score",     32'(score_s),     to_bcd(ms.sc));
         check("s_hiscore",   32'(hiscore_s),   to_bcd(ms.hi));
         check("s_new_hi",    32'(new_hi_s),    32'(ms.nh));
         check("s_milestone", 32'(milestone_s), 32'(ms.ms));
         check("s_saturated", 32'(saturated_s), 32'(ms.sat));
         ms_cnt   += int'(milestone);
         ms_cnt_s += int'(milestone_s);
      end
   end

   task automatic drv(bit rn, bit cl, bit ie, logic [3:0] a, bit cm);
      @(negedge clk);
      resetn  = rn;
      clear   = cl;
      inc_en  = ie;
      inc_amt = a;
      commit  = cm;
   endtask

   task automatic idle();
      drv(1, 0, 0, 4'd0, 0);
   endtask

   task automatic inc(logic [3:0] a);
      drv(1, 0, 1, a, 0);
   endtask

   initial begin
      drv(0, 0, 0, 4'd0, 0);
      drv(0, 0, 1, 4'd5, 1);
      idle();
      #1;
      chk_en = 1'b1;
      check("lit_reset_score", 32'(score), 32'h0);
      check("lit_reset_flags", {29'd0, new_hi, milestone, saturated}, 32'h0);

      // ten single steps, no milestone
      base = ms_cnt;
      repeat (10) inc(4'd1);
      idle();
      #1;
      check("lit_t1_score", 32'(score), 32'h000010);
      check("lit_t1_ms", ms_cnt - base, 0);

      // 95 + 7 crosses into the hundreds digit
      base = ms_cnt;
      repeat (9) inc(4'd9);
      inc(4'd4);
      idle();
      #1;
      check("lit_t2_pre", 32'(score), 32'h000095);
      inc(4'd7);
      idle();
      #1;
      check("lit_t2_score", 32'(score), 32'h000102);
      check("lit_t2_ms", ms_cnt - base, 1);

      // saturation on the 3-digit instance
      drv(0, 0, 0, 4'd0, 0);
      idle();
      repeat (110) inc(4'd9);
      inc(4'd5);
      idle();
      #1;
      check("lit_t3_pre", 32'(score_s), 32'h995);
      inc(4'd9);
      idle();
      #1;
      check("lit_t3_sat_score", 32'(score_s), 32'h999);
      check("lit_t3_sat_flag", 32'(saturated_s), 32'h1);
      check("lit_t3_sat_ms", 32'(milestone_s), 32'h0);
      inc(4'd3);
      idle();
      #1;
      check("lit_t3_held", 32'(score_s), 32'h999);
      drv(1, 1, 0, 4'd0, 0);
      idle();
      #1;
      check("lit_t3_clear", {19'd0, saturated_s, score_s}, 32'h0);

      // clamp and zero step
      inc(4'd15);
      idle();
      #1;
      check("lit_t4_clamp", 32'(score), 32'h000009);
      inc(4'd0);
      idle();
      #1;
      check("lit_t4_zero", 32'(score), 32'h000009);

      // commit behaviour
      repeat (12) inc(4'd9);
      inc(4'd3);
      idle();
      #1;
      check("lit_t5_pre", 32'(score), 32'h000120);
      drv(1, 0, 0, 4'd0, 1);
      idle();
      #1;
      check("lit_t5_hi", 32'(hiscore), 32'h000120);
      check("lit_t5_new_hi", 32'(new_hi), 32'h1);
      drv(1, 0, 0, 4'd0, 1);
      idle();
      #1;
      check("lit_t5_no_new_hi", 32'(new_hi), 32'h0);
      inc(4'd9);
      inc(4'd1);
      drv(1, 0, 1, 4'd4, 1);
      idle();
      #1;
      check("lit_t5_commit_inc_hi", 32'(hiscore), 32'h000130);
      check("lit_t5_commit_inc_sc", 32'(score), 32'h000134);
      drv(1, 1, 0, 4'd0, 1);
      idle();
      #1;
      check("lit_t5_cc_hi", 32'(hiscore), 32'h000134);
      check("lit_t5_cc_score", 32'(score), 32'h0);

      // clear beats increment, reset mid-burst
      inc(4'd5);
      drv(1, 1, 1, 4'd9, 0);
      idle();
      #1;
      check("lit_t6_clr_inc", 32'(score), 32'h0);
      inc(4'd3);
      inc(4'd4);
      drv(0, 0, 1, 4'd2, 0);
      @(negedge clk);
      #1;
      check("lit_t6_rst_score", 32'(score), 32'h0);
      check("lit_t6_rst_hi", 32'(hiscore), 32'h0);
      check("lit_t6_rst_flags", {29'd0, new_hi, milestone, saturated}, 32'h0);
      inc(4'd6);
      idle();
      #1;
      check("lit_t6_after", 32'(score), 32'h000006);
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
